// File: rtl/add_issue_ctrl.sv
// add_issue_ctrl: operand FIFO feeding a serial adder with one op in flight; optional WAIT timeout under ADD_ISSUE_TIMEOUT_EN
module add_issue_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic       add_start,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  input  logic [7:0] add_c,
  input  logic       add_done,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       busy
`ifdef ADD_ISSUE_TIMEOUT_EN
  ,
  output logic       timeout_err
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;
  state_t state, state_n;
  logic [7:0] mem_a [FIFO_DEPTH];
  logic [7:0] mem_b [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic full, empty, push, pop, tmo;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign in_ready = !full;
  assign push = in_valid && !full;
  assign pop = state == START;
  assign add_start = state == START;
  assign busy = state != IDLE;
`ifdef ADD_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  assign tmo = state == WAIT && !add_done && tcnt == TW'(TIMEOUT_CYC - 1);
  // WAIT cycle counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      tcnt <= (state == WAIT) ? tcnt + 1'b1 : '0;
      if (tmo) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif
  // operand storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end
  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // next state: issue only when no result is waiting to be consumed
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = (!empty && !res_valid) ? START : IDLE;
      START: state_n = WAIT;
      WAIT: state_n = (add_done || tmo) ? GAP : WAIT;
      default: state_n = IDLE;
    endcase
  end
  // operand latch on issue and result capture/handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      add_a <= '0;
      add_b <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
    end else begin
      if (state == IDLE && state_n == START) begin
        add_a <= mem_a[rd_ptr];
        add_b <= mem_b[rd_ptr];
      end
      if (state == WAIT && add_done) begin
        res_data <= add_c;
        res_valid <= 1'b1;
      end else if (tmo) begin
        res_data <= 8'hFF;
        res_valid <= 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule
